// File: rtl/atan_ratio_div_if.sv
// Operand/result handshake bundle for the atan ratio divider.
// The master drives the operands and out_ready; the slave (divider) returns the ratio.
interface atan_ratio_div_if #(
    parameter int DW = 16,
    parameter int QW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] num_i;
    logic [DW-1:0] den_i;
    logic          out_valid;
    logic          out_ready;
    logic [QW-1:0] ratio_o;
    logic          sat_o;
    logic          dz_o;

    modport master (
        output in_valid, num_i, den_i, out_ready,
        input  in_ready, out_valid, ratio_o, sat_o, dz_o
    );

    modport slave (
        input  in_valid, num_i, den_i, out_ready,
        output in_ready, out_valid, ratio_o, sat_o, dz_o
    );
endinterface

// File: rtl/atan_ratio_div.sv
// Restoring divider producing floor(num*2^QW/den) as the fractional input of the atan polynomial.
// One quotient bit per cycle; zero and num>=den denominators saturate to all ones.
module atan_ratio_div #(
    parameter int DW = 16,
    parameter int QW = 8
) (
    input  logic            clk,
    input  logic            rst,
    atan_ratio_div_if.slave bus
);
    localparam int CW = (QW > 1) ? $clog2(QW) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [DW:0]   rem_q,   rem_d;
    logic [DW-1:0] den_q,   den_d;
    logic [QW-1:0] quo_q,   quo_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          sat_q,   sat_d;
    logic          dz_q,    dz_d;

    logic [DW:0]   rem_shl;
    logic [DW:0]   den_ext;
    logic          step_bit;

    // The remainder stays below den, so the shifted value always fits in DW+1 bits.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d  = state_q;
        rem_d    = rem_q;
        den_d    = den_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        dz_d     = dz_q;
        rem_shl  = {rem_q[DW-1:0], 1'b0};
        den_ext  = {1'b0, den_q};
        step_bit = (rem_shl >= den_ext);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = CALC;
                    den_d   = bus.den_i;
                    if (bus.den_i == '0) begin
                        quo_d = '1;
                        dz_d  = 1'b1;
                        sat_d = 1'b0;
                        rem_d = '0;
                        cnt_d = '0;
                    end else if (bus.num_i >= bus.den_i) begin
                        quo_d = '1;
                        sat_d = 1'b1;
                        dz_d  = 1'b0;
                        rem_d = '0;
                        cnt_d = '0;
                    end else begin
                        quo_d = '0;
                        sat_d = 1'b0;
                        dz_d  = 1'b0;
                        rem_d = {1'b0, bus.num_i};
                        cnt_d = CW'(QW - 1);
                    end
                end
            end
            CALC: begin
                // Saturated results pass through CALC once untouched, giving a one-edge latency.
                if (sat_q || dz_q) begin
                    state_d = DONE;
                end else begin
                    rem_d = step_bit ? (rem_shl - den_ext) : rem_shl;
                    quo_d = (quo_q << 1) | QW'(step_bit);
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            den_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            den_q   <= den_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.ratio_o   = quo_q;
    assign bus.sat_o     = sat_q;
    assign bus.dz_o      = dz_q;
endmodule
